// File: rtl/rtype_pkg.sv
// rtype_pkg: shared ALU select codes, RV32 R-type field constants, stage states and decoder
package rtype_pkg;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
    typedef struct packed {
        logic       legal;
        logic [3:0] sel;
        logic       shift;
    } dec_t;
    // Only the base-funct7 encodings plus SUB are supported; SLTU and SRA are rejected.
    function automatic dec_t decode(input logic [31:0] i);
        dec_t d;
        logic base, alt;
        base = (i[6:0] == OPC_RTYPE) && (i[31:25] == F7_BASE);
        alt  = (i[6:0] == OPC_RTYPE) && (i[31:25] == F7_ALT) && (i[14:12] == F3_ADD);
        case (i[14:12])
            F3_ADD:  d.sel = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  d.sel = ALU_SLL;
            F3_SLT:  d.sel = ALU_SLT;
            F3_XOR:  d.sel = ALU_XOR;
            F3_SRL:  d.sel = ALU_SRL;
            F3_OR:   d.sel = ALU_OR;
            default: d.sel = ALU_AND;
        endcase
        d.legal = alt || (base && i[14:12] != F3_SLTU);
        d.shift = base && (i[14:12] == F3_SLL || i[14:12] == F3_SRL);
        return d;
    endfunction
endpackage

// File: rtl/rtype_issue_stage_regfile.sv
// rtype_issue_stage_regfile: register file with x0 hardwired to zero
//   rs1/rs2/dbg: combinational read ports (address in, data out)
//   we/waddr/wdata: synchronous write port; writes to x0 are dropped
//   rst: synchronous clear of every register
module rtype_issue_stage_regfile #(
    parameter int DATA_W    = 32,
    parameter int REG_COUNT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        rs1_addr,
    output logic [DATA_W-1:0] rs1_data,
    input  logic [4:0]        rs2_addr,
    output logic [DATA_W-1:0] rs2_data,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              we,
    input  logic [4:0]        waddr,
    input  logic [DATA_W-1:0] wdata
);
    logic [DATA_W-1:0] regs [REG_COUNT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];
    assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];
endmodule

// File: rtl/rtype_issue_stage.sv
// rtype_issue_stage: non-pipelined decode/operand-fetch/write-back stage for an R-type ALU
//   instr_valid/instr_ready/instr: instruction handshake, accepted only in IDLE
//   ld_en/ld_addr/ld_data: register preload, honoured in IDLE only (blocks accept)
//   alu_a/alu_b/alu_sel -> external ALU, alu_result <- ALU (captured at end of EXEC)
//   retire_valid/rd/data: write-back pulse; illegal_instr: reject pulse
//   dbg_addr/dbg_data: combinational register peek
module rtype_issue_stage
    import rtype_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int REG_COUNT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    input  logic              ld_en,
    input  logic [4:0]        ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    output logic              retire_valid,
    output logic [4:0]        retire_rd,
    output logic [DATA_W-1:0] retire_data,
    output logic              illegal_instr,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    state_t            state, state_n;
    dec_t              dec;
    logic              accept, we;
    logic [4:0]        rd_q, waddr;
    logic [DATA_W-1:0] result_q, wdata, rs1_val, rs2_val;

    assign dec          = decode(instr);
    assign instr_ready  = (state == IDLE) && !ld_en;
    assign accept       = instr_valid && instr_ready;
    assign retire_valid = (state == WB);
    assign retire_rd    = rd_q;
    assign retire_data  = result_q;

    // Write-back owns the port in WB; preload only reaches it while IDLE.
    assign we    = (state == WB) || (ld_en && state == IDLE);
    assign waddr = (state == WB) ? rd_q : ld_addr;
    assign wdata = (state == WB) ? result_q : ld_data;

    rtype_issue_stage_regfile #(.DATA_W(DATA_W), .REG_COUNT(REG_COUNT)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (instr[19:15]),
        .rs1_data (rs1_val),
        .rs2_addr (instr[24:20]),
        .rs2_data (rs2_val),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata)
    );

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end

    always_comb begin
        state_n = (state == IDLE) ? ((accept && dec.legal) ? EXEC : IDLE) :
                  (state == EXEC) ? WB : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a         <= '0;
            alu_b         <= '0;
            alu_sel       <= '0;
            rd_q          <= '0;
            result_q      <= '0;
            illegal_instr <= 1'b0;
        end else begin
            illegal_instr <= accept && !dec.legal;
            if (accept && dec.legal) begin
                alu_a   <= rs1_val;
                alu_b   <= dec.shift ? {{(DATA_W-5){1'b0}}, rs2_val[4:0]} : rs2_val;
                alu_sel <= dec.sel;
                rd_q    <= instr[11:7];
            end
            if (state == EXEC) result_q <= alu_result;
        end
    end
endmodule

// File: tb/tb_rtype_issue_stage.sv
// tb_rtype_issue_stage: directed table-driven bench with a reference ALU on the stage outputs
module tb_rtype_issue_stage;
    localparam logic [6:0] OPC = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic        ld_en = 1'b0;
    logic [4:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic [31:0] alu_a, alu_b, alu_result, retire_data, dbg_data;
    logic [3:0]  alu_sel;
    logic        retire_valid, illegal_instr;
    logic [4:0]  retire_rd;
    logic [4:0]  dbg_addr = '0;

    int tests = 0;
    int fails = 0;

    rtype_issue_stage dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .ld_en        (ld_en),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_sel      (alu_sel),
        .alu_result   (alu_result),
        .retire_valid (retire_valid),
        .retire_rd    (retire_rd),
        .retire_data  (retire_data),
        .illegal_instr(illegal_instr),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_sel)
            4'h0:    alu_result = alu_a & alu_b;
            4'h1:    alu_result = alu_a | alu_b;
            4'h2:    alu_result = alu_a + alu_b;
            4'h3:    alu_result = alu_a ^ alu_b;
            4'h4:    alu_result = alu_a << alu_b[4:0];
            4'h5:    alu_result = alu_a >> alu_b[4:0];
            4'h6:    alu_result = alu_a - alu_b;
            4'h7:    alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
            default: alu_result = '0;
        endcase
    end

    typedef struct {
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [6:0]  opc;
        logic [31:0] a, b;
        logic        legal;
        logic [3:0]  sel;
        logic [31:0] eb, res;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic ld(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic dbg(input string name, input logic [4:0] a, input logic [31:0] exp);
        dbg_addr = a;
        #1;
        chk(name, dbg_data, exp);
    endtask

    // Offers one instruction for exactly one cycle; returns in cycle A+1 just after the negedge.
    task automatic issue(input logic [31:0] ins);
        @(negedge clk);
        instr = ins; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    initial begin
        logic [31:0] x3m;
        logic [3:0]  last_sel;
        tbl[0]  = '{7'h00, 3'b000, OPC, 32'h0000000A, 32'h00000005, 1'b1, 4'h2, 32'h00000005, 32'h0000000F};
        tbl[1]  = '{7'h20, 3'b000, OPC, 32'h00000005, 32'h00000003, 1'b1, 4'h6, 32'h00000003, 32'h00000002};
        tbl[2]  = '{7'h00, 3'b001, OPC, 32'h00000001, 32'h00000023, 1'b1, 4'h4, 32'h00000003, 32'h00000008};
        tbl[3]  = '{7'h00, 3'b010, OPC, 32'hFFFFFFFF, 32'h00000001, 1'b1, 4'h7, 32'h00000001, 32'h00000001};
        tbl[4]  = '{7'h00, 3'b100, OPC, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b1, 4'h3, 32'h0FF00FF0, 32'hFF00FF00};
        tbl[5]  = '{7'h00, 3'b101, OPC, 32'h80000000, 32'hFFFFFFE4, 1'b1, 4'h5, 32'h00000004, 32'h08000000};
        tbl[6]  = '{7'h00, 3'b110, OPC, 32'h00FF0000, 32'h000000FF, 1'b1, 4'h1, 32'h000000FF, 32'h00FF00FF};
        tbl[7]  = '{7'h00, 3'b111, OPC, 32'hFFFF0000, 32'h0F0F0F0F, 1'b1, 4'h0, 32'h0F0F0F0F, 32'h0F0F0000};
        tbl[8]  = '{7'h00, 3'b011, OPC, 32'h00000001, 32'h00000002, 1'b0, 4'h0, 32'h0, 32'h0};
        tbl[9]  = '{7'h20, 3'b101, OPC, 32'h80000000, 32'h00000001, 1'b0, 4'h0, 32'h0, 32'h0};
        tbl[10] = '{7'h00, 3'b000, 7'b0010011, 32'h00000001, 32'h00000002, 1'b0, 4'h0, 32'h0, 32'h0};
        tbl[11] = '{7'h01, 3'b000, OPC, 32'h00000003, 32'h00000004, 1'b0, 4'h0, 32'h0, 32'h0};

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", {31'b0, instr_ready}, 32'd1);
        chk("rst_retire", {31'b0, retire_valid}, 32'd0);
        chk("rst_illegal", {31'b0, illegal_instr}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        for (int i = 0; i < 32; i++) dbg("rst_reg", 5'(i), 32'd0);

        // SUB x3,x1,x2
        ld(5'd1, 32'd5);
        ld(5'd2, 32'd3);
        ld(5'd0, 32'h123);
        dbg("x0_preload_ignored", 5'd0, 32'd0);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 5'd9;
        #1 chk("ready_blocked_by_ld", {31'b0, instr_ready}, 32'd0);
        ld_en = 1'b0;
        issue(32'h402081B3);
        chk("sub_a", alu_a, 32'd5);
        chk("sub_b", alu_b, 32'd3);
        chk("sub_sel", {28'b0, alu_sel}, 32'h6);
        chk("sub_exec_ready", {31'b0, instr_ready}, 32'd0);
        chk("sub_exec_retire", {31'b0, retire_valid}, 32'd0);
        @(negedge clk);
        chk("sub_retire", {31'b0, retire_valid}, 32'd1);
        chk("sub_rd", {27'b0, retire_rd}, 32'd3);
        chk("sub_data", retire_data, 32'd2);
        chk("sub_wb_ready", {31'b0, instr_ready}, 32'd0);
        @(negedge clk);
        chk("sub_a3_ready", {31'b0, instr_ready}, 32'd1);
        chk("sub_a3_retire", {31'b0, retire_valid}, 32'd0);
        dbg("sub_x3", 5'd3, 32'd2);

        // SLL x4,x1,x5 with shift amount masked to 5 bits
        ld(5'd5, 32'h00000021);
        issue(32'h00509233);
        chk("sll_b", alu_b, 32'd1);
        chk("sll_sel", {28'b0, alu_sel}, 32'h4);
        repeat (2) @(negedge clk);
        dbg("sll_x4", 5'd4, 32'd10);

        // Illegal SRA
        issue(32'h4020D1B3);
        chk("sra_illegal", {31'b0, illegal_instr}, 32'd1);
        chk("sra_ready", {31'b0, instr_ready}, 32'd1);
        chk("sra_no_retire", {31'b0, retire_valid}, 32'd0);
        chk("sra_sel_hold", {28'b0, alu_sel}, 32'h4);
        @(negedge clk);
        chk("sra_illegal_once", {31'b0, illegal_instr}, 32'd0);
        chk("sra_no_retire2", {31'b0, retire_valid}, 32'd0);
        dbg("sra_x3", 5'd3, 32'd2);

        // ADD x0,x1,x2
        issue(32'h00208033);
        @(negedge clk);
        chk("x0_retire", {31'b0, retire_valid}, 32'd1);
        chk("x0_rd", {27'b0, retire_rd}, 32'd0);
        chk("x0_data", retire_data, 32'd8);
        @(negedge clk);
        dbg("x0_stays_zero", 5'd0, 32'd0);

        // Table of operations: rd=x3, rs1=x1, rs2=x2
        x3m = 32'hDEADBEEF;
        last_sel = 4'h2;
        ld(5'd3, x3m);
        foreach (tbl[i]) begin
            ld(5'd1, tbl[i].a);
            ld(5'd2, tbl[i].b);
            issue(enc(tbl[i].f7, 5'd2, 5'd1, tbl[i].f3, 5'd3, tbl[i].opc));
            chk("tbl_illegal", {31'b0, illegal_instr}, {31'b0, !tbl[i].legal});
            if (tbl[i].legal) begin
                chk("tbl_a", alu_a, tbl[i].a);
                chk("tbl_b", alu_b, tbl[i].eb);
                chk("tbl_sel", {28'b0, alu_sel}, {28'b0, tbl[i].sel});
                last_sel = tbl[i].sel;
                x3m = tbl[i].res;
            end else begin
                chk("tbl_sel_hold", {28'b0, alu_sel}, {28'b0, last_sel});
                chk("tbl_ill_ready", {31'b0, instr_ready}, 32'd1);
            end
            @(negedge clk);
            chk("tbl_retire", {31'b0, retire_valid}, {31'b0, tbl[i].legal});
            chk("tbl_no_illegal", {31'b0, illegal_instr}, 32'd0);
            if (tbl[i].legal) begin
                chk("tbl_rd", {27'b0, retire_rd}, 32'd3);
                chk("tbl_data", retire_data, tbl[i].res);
            end
            @(negedge clk);
            dbg("tbl_x3", 5'd3, x3m);
        end

        // Back-to-back with instr_valid held high; preload during EXEC is ignored
        ld(5'd1, 32'd5);
        ld(5'd2, 32'd3);
        @(negedge clk);
        instr = 32'h402081B3; instr_valid = 1'b1;
        @(negedge clk);
        instr = enc(7'h00, 5'd3, 5'd3, 3'b000, 5'd6, OPC);
        ld_en = 1'b1; ld_addr = 5'd7; ld_data = 32'h55;
        #1 chk("b2b_ready_a1", {31'b0, instr_ready}, 32'd0);
        @(negedge clk);
        ld_en = 1'b0;
        chk("b2b_ready_a2", {31'b0, instr_ready}, 32'd0);
        @(negedge clk);
        chk("b2b_ready_a3", {31'b0, instr_ready}, 32'd1);
        @(negedge clk);
        instr_valid = 1'b0;
        chk("b2b_a", alu_a, 32'd2);
        chk("b2b_b", alu_b, 32'd2);
        chk("b2b_sel", {28'b0, alu_sel}, 32'h2);
        @(negedge clk);
        chk("b2b_retire", {31'b0, retire_valid}, 32'd1);
        chk("b2b_rd", {27'b0, retire_rd}, 32'd6);
        chk("b2b_data", retire_data, 32'd4);
        @(negedge clk);
        dbg("b2b_x6", 5'd6, 32'd4);
        dbg("exec_ld_ignored", 5'd7, 32'd0);

        // Reset during EXEC discards the instruction
        issue(32'h402081B3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_exec_retire", {31'b0, retire_valid}, 32'd0);
        chk("rst_exec_ready", {31'b0, instr_ready}, 32'd1);
        @(negedge clk);
        chk("rst_exec_retire2", {31'b0, retire_valid}, 32'd0);
        dbg("rst_exec_x1", 5'd1, 32'd0);
        dbg("rst_exec_x3", 5'd3, 32'd0);
        dbg("rst_exec_x6", 5'd6, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    always @(negedge clk) begin
        if (retire_valid && illegal_instr) begin
            tests++;
            fails++;
            $display("FAIL excl: retire_valid and illegal_instr both 1, required not both");
        end
    end
endmodule
